// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port data-memory arbiter: FSM encoding and port indices.
package mem_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin picker; with MEM_ARBITER_LOCK_EN a held lock
// restricts the choice to the current owner.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic       locked,
  input  logic       owner,
`endif
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = prio;
`ifdef MEM_ARBITER_LOCK_EN
    if (locked) begin
      grant_valid = req[owner];
      grant_idx   = owner;
    end else begin
`else
    begin
`endif
      case (req)
        2'b01:   begin grant_valid = 1'b1; grant_idx = PORT_CPU; end
        2'b10:   begin grant_valid = 1'b1; grant_idx = PORT_AUX; end
        2'b11:   begin grant_valid = 1'b1; grant_idx = prio;     end
        default: begin grant_valid = 1'b0; grant_idx = prio;     end
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port synchronous memory.
// Optional feature macro: MEM_ARBITER_LOCK_EN (adds lock input for atomic sequences).
//
// Handshake: a master raises req[i] with we/addr/wdata stable and holds them until it
// samples ack[i]=1 (a one-cycle pulse); it drops req on that same edge. rdata is valid
// while ack is high for a read.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic [1:0]              lock,
`endif
  output logic [1:0]              ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic                    owner,
  output logic [1:0]              dbg_state,
  input  logic [DATA_WIDTH-1:0]   mem_in,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data
);

  logic [1:0]            state;
  logic                  prio;
  logic                  owner_q;
  logic [2:0]            wait_cnt;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  grant_valid;
  logic                  grant_idx;
`ifdef MEM_ARBITER_LOCK_EN
  logic                  locked;
`endif

  rr_pick u_pick (
    .req         (req),
    .prio        (prio),
`ifdef MEM_ARBITER_LOCK_EN
    .locked      (locked),
    .owner       (owner_q),
`endif
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= PORT_CPU;
      owner_q   <= PORT_CPU;
      wait_cnt  <= 3'd0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
`ifdef MEM_ARBITER_LOCK_EN
      locked    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_q   <= grant_idx;
            cmd_we    <= we[grant_idx];
            cmd_addr  <= grant_idx ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
            cmd_wdata <= grant_idx ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_we) begin
            state <= DONE;
          end else begin
            wait_cnt <= 3'(READ_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            rdata_q <= mem_in;
            state   <= DONE;
          end
        end
        DONE: begin
`ifdef MEM_ARBITER_LOCK_EN
          // A held lock keeps priority with the owner so its next access follows directly.
          if (lock[owner_q]) begin
            locked <= 1'b1;
          end else begin
            locked <= 1'b0;
            prio   <= ~owner_q;
          end
`else
          prio <= ~owner_q;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command registers only change on accept, so the memory bus holds its last value when idle.
  assign mem_addr  = cmd_addr;
  assign mem_data  = cmd_wdata;
  assign mem_we    = (state == ISSUE) && cmd_we;
  assign ack       = (state == DONE) ? port_onehot(owner_q) : 2'b00;
  assign rdata     = rdata_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;
  assign dbg_state = state;

endmodule
